// File: rtl/hdb3_decoder.sv
// hdb3_decoder: HDB3 line decoder that turns dual-rail BP/BN symbols back into NRZ data.
//               It detects bipolar violations, removes 000V/B00V substitutions and reports code errors.
module hdb3_decoder #(
    parameter int ZERO_LIMIT = 3,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             BP,
    input  logic             BN,
    output logic             data_out,
    output logic             data_vld,
    output logic             viol,
    output logic             code_err,
    output logic [ERR_W-1:0] err_cnt
);
    // zrun saturates one past the limit, so the error fires once per long run
    localparam int ZW = $clog2(ZERO_LIMIT + 2);

    typedef enum logic {HUNT, LOCK} state_t;

    state_t           state_q, state_d;
    logic             last_pol_q, last_pol_d;
    logic             v_seen_q, v_seen_d;
    logic             last_v_pol_q, last_v_pol_d;
    logic [3:0]       p_q, p_d;
    logic [2:0]       fill_q, fill_d;
    logic [ZW-1:0]    zrun_q, zrun_d;
    logic             data_out_q, data_out_d;
    logic             data_vld_q, data_vld_d;
    logic             viol_q, viol_d;
    logic             code_err_q, code_err_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic             pos, ill, mark, is_v, zexc, vbad, err;

    // Classify the symbol, then compute the next polarity, pipeline and error state
    always_comb begin
        pos          = BP & ~BN;
        ill          = BP & BN;
        mark         = BP ^ BN;
        is_v         = (state_q == LOCK) && mark && (pos == last_pol_q);
        zexc         = ~mark && (zrun_q == ZW'(ZERO_LIMIT));
        vbad         = is_v && v_seen_q && (pos == last_v_pol_q);
        err          = ill || ((state_q == LOCK) && (zexc || vbad));
        state_d      = mark ? LOCK : state_q;
        last_pol_d   = mark ? pos : last_pol_q;
        v_seen_d     = v_seen_q | is_v;
        last_v_pol_d = is_v ? pos : last_v_pol_q;
        p_d          = is_v ? 4'b0000 : {p_q[2:0], mark};
        data_out_d   = p_q[3];
        fill_d       = (fill_q == 3'd4) ? fill_q : fill_q + 3'd1;
        data_vld_d   = (fill_q == 3'd4);
        zrun_d       = mark ? '0 : (zrun_q == ZW'(ZERO_LIMIT + 1)) ? zrun_q : zrun_q + ZW'(1);
        viol_d       = is_v;
        code_err_d   = err;
        err_cnt_d    = (err && (err_cnt_q != '1)) ? err_cnt_q + ERR_W'(1) : err_cnt_q;
    end

    // Register all state and outputs; reset overrides everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= HUNT;
            last_pol_q   <= 1'b0;
            v_seen_q     <= 1'b0;
            last_v_pol_q <= 1'b0;
            p_q          <= '0;
            fill_q       <= '0;
            zrun_q       <= '0;
            data_out_q   <= 1'b0;
            data_vld_q   <= 1'b0;
            viol_q       <= 1'b0;
            code_err_q   <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_pol_q   <= last_pol_d;
            v_seen_q     <= v_seen_d;
            last_v_pol_q <= last_v_pol_d;
            p_q          <= p_d;
            fill_q       <= fill_d;
            zrun_q       <= zrun_d;
            data_out_q   <= data_out_d;
            data_vld_q   <= data_vld_d;
            viol_q       <= viol_d;
            code_err_q   <= code_err_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign data_out = data_out_q;
    assign data_vld = data_vld_q;
    assign viol     = viol_q;
    assign code_err = code_err_q;
    assign err_cnt  = err_cnt_q;
endmodule

// File: tb/tb_hdb3_decoder.sv
// tb_hdb3_decoder: directed checks of the HDB3 decoder with hand-computed expectations.
module tb_hdb3_decoder;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       BP = 1'b0;
    logic       BN = 1'b0;
    logic       data_out, data_vld, viol, code_err;
    logic [7:0] err_cnt;
    int         checks = 0;
    int         errors = 0;

    hdb3_decoder #(.ZERO_LIMIT(3), .ERR_W(8)) dut (
        .clk(clk), .rst(rst), .BP(BP), .BN(BN),
        .data_out(data_out), .data_vld(data_vld), .viol(viol),
        .code_err(code_err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // drive one symbol, clock it in, sample 1 time unit after the edge
    task automatic sym(input logic bp, input logic bn);
        BP = bp;
        BN = bn;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        BP = 1'b0;
        BN = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        do_reset();
        chk("rst_data", data_out, 0);
        chk("rst_vld", data_vld, 0);
        chk("rst_viol", viol, 0);
        chk("rst_err", code_err, 0);
        chk("rst_cnt", err_cnt, 0);

        // T1: alternating marks decode to ones, data_vld rises at edge 5
        sym(1, 0); sym(0, 1); sym(1, 0); sym(0, 1);
        chk("t1_vld_e4", data_vld, 0);
        sym(1, 0);
        chk("t1_vld_e5", data_vld, 1);
        chk("t1_d5", data_out, 1);
        chk("t1_viol5", viol, 0);
        sym(0, 1); chk("t1_d6", data_out, 1);
        sym(1, 0); chk("t1_d7", data_out, 1);
        sym(0, 1); chk("t1_d8", data_out, 1);
        chk("t1_err", code_err, 0);
        chk("t1_viol8", viol, 0);

        // T2: + 0 0 0 V+ then alternating
        do_reset();
        sym(1, 0); sym(0, 0); sym(0, 0); sym(0, 0);
        chk("t2_viol4", viol, 0);
        sym(1, 0);
        chk("t2_viol5", viol, 1);
        chk("t2_d5", data_out, 1);
        chk("t2_err5", code_err, 0);
        sym(0, 1); chk("t2_viol6", viol, 0); chk("t2_d6", data_out, 0);
        sym(1, 0); chk("t2_d7", data_out, 0);
        sym(0, 1); chk("t2_d8", data_out, 0);
        sym(1, 0); chk("t2_d9", data_out, 0);
        sym(0, 1); chk("t2_d10", data_out, 1);

        // T3: + - 0 0 V- : the B on symbol 2 is removed
        do_reset();
        sym(1, 0); sym(0, 1); sym(0, 0); sym(0, 0); sym(0, 1);
        chk("t3_viol5", viol, 1);
        chk("t3_d5", data_out, 1);
        sym(1, 0); chk("t3_viol6", viol, 0); chk("t3_d6", data_out, 0);
        sym(0, 1); chk("t3_d7", data_out, 0);
        sym(1, 0); chk("t3_d8", data_out, 0);
        sym(0, 1); chk("t3_d9", data_out, 0);
        sym(1, 0); chk("t3_d10", data_out, 1);

        // T4: illegal symbol in LOCK
        do_reset();
        sym(1, 0); sym(0, 1); sym(1, 1);
        chk("t4_err", code_err, 1);
        chk("t4_cnt", err_cnt, 1);
        chk("t4_viol", viol, 0);
        sym(1, 0);
        chk("t4_err_clr", code_err, 0);
        chk("t4_cnt_hold", err_cnt, 1);
        sym(0, 1); chk("t4_d5", data_out, 1);
        sym(1, 0); chk("t4_d6", data_out, 1);
        sym(0, 1); chk("t4_d7", data_out, 0);

        // T5a: four zeros after a mark in LOCK
        do_reset();
        sym(1, 0); sym(0, 0); sym(0, 0); sym(0, 0);
        chk("t5_err_3z", code_err, 0);
        sym(0, 0);
        chk("t5_err_4z", code_err, 1);
        chk("t5_cnt_4z", err_cnt, 1);

        // T5b: two consecutive V+ -> error on the second V
        do_reset();
        sym(1, 0); sym(0, 0); sym(0, 0); sym(0, 0); sym(1, 0);
        chk("t5_v1", viol, 1);
        chk("t5_v1_err", code_err, 0);
        sym(0, 1); sym(1, 0); sym(0, 0); sym(0, 0);
        chk("t5_pre_v2", code_err, 0);
        sym(1, 0);
        chk("t5_v2", viol, 1);
        chk("t5_v2_err", code_err, 1);
        chk("t5_v2_cnt", err_cnt, 1);

        // T6: saturate err_cnt, then reset mid-stream
        do_reset();
        sym(1, 0);
        for (int i = 0; i < 255; i++) sym(1, 1);
        chk("t6_cnt255", err_cnt, 8'hff);
        sym(1, 1);
        chk("t6_err_sat", code_err, 1);
        chk("t6_cnt_sat", err_cnt, 8'hff);
        rst = 1'b1;
        sym(1, 0);
        chk("t6_rst_data", data_out, 0);
        chk("t6_rst_vld", data_vld, 0);
        chk("t6_rst_viol", viol, 0);
        chk("t6_rst_err", code_err, 0);
        chk("t6_rst_cnt", err_cnt, 0);
        rst = 1'b0;
        sym(1, 0);
        chk("t6_hunt_viol", viol, 0);
        sym(1, 0);
        chk("t6_lock_viol", viol, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
